// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard sequencer: FSM state encoding,
// boundary indices and the per-state stack beat count.
package hazard_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CALL = 3'd1,
    ST_RET  = 3'd2,
    ST_RTI  = 3'd3,
    ST_INT  = 3'd4
  } state_e;

  localparam int B_FD = 0;

  // CALL/RET move only the PC; RTI and interrupt entry also move the flags.
  function automatic int seq_beats(input state_e s, input int pc_beats,
                                   input int flag_beats);
    case (s)
      ST_CALL, ST_RET: return pc_beats;
      ST_RTI, ST_INT:  return pc_beats + flag_beats;
      default:         return 0;
    endcase
  endfunction

endpackage

// File: rtl/stack_beat_counter.sv
// Stack beat counter: load to 1 on sequence entry, step per beat, clear on
// release; terminal count flags the release cycle.
module stack_beat_counter #(
  parameter int CNT_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_inc,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_beats,
  output logic [CNT_W-1:0] o_count,
  output logic             o_tc
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      cnt_q <= '0;
    end else if (i_load) begin
      cnt_q <= CNT_W'(1);
    end else if (i_inc) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign o_count = cnt_q;
  assign o_tc    = (cnt_q == i_beats);

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: per-boundary stall/flush, PC redirect and
// interrupt acknowledge, with multi-beat CALL/RET/RTI/INT stack sequences.
module hazard_sequencer
  import hazard_pkg::*;
#(
  parameter int N_STAGES   = 3,
  parameter int PC_BEATS   = 2,
  parameter int FLAG_BEATS = 1,
  localparam int N_B       = N_STAGES - 1,
  localparam int CNT_W     = $clog2(PC_BEATS + FLAG_BEATS + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push_pc,
  input  logic             i_pop_pc,
  input  logic             i_rti,
  input  logic             i_branch_decision,
  input  logic             i_load_use,
  input  logic             i_exm_imm,
  input  logic             i_interrupt_req,
  output logic [N_B-1:0]   o_stall,
  output logic [N_B-1:0]   o_flush,
  output logic             o_branch_decision,
  output logic [CNT_W-1:0] o_stack_beat,
  output logic             o_stack_en,
  output logic             o_interrupt_ack,
  output logic             o_int_blocked,
  output logic [2:0]       o_state
);

  localparam int B_LAST = N_B - 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count, beats;
  logic             cnt_load, cnt_inc, cnt_clr, cnt_tc;
  logic [N_B-1:0]   stall_raw, flush_v;
  logic             int_ok;

  assign int_ok = i_interrupt_req & ~(i_push_pc | i_pop_pc | i_rti | i_load_use);
  assign beats  = CNT_W'(seq_beats(state_q, PC_BEATS, FLAG_BEATS));

  stack_beat_counter #(.CNT_W(CNT_W)) u_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (cnt_load),
    .i_inc   (cnt_inc),
    .i_clr   (cnt_clr),
    .i_beats (beats),
    .o_count (count),
    .o_tc    (cnt_tc)
  );

  always_comb begin
    state_d           = state_q;
    cnt_load          = 1'b0;
    cnt_inc           = 1'b0;
    cnt_clr           = 1'b0;
    stall_raw         = '0;
    flush_v           = '0;
    o_branch_decision = 1'b0;
    o_stack_en        = 1'b0;
    o_stack_beat      = '0;
    o_interrupt_ack   = 1'b0;

    if (state_q == ST_IDLE) begin
      if (i_push_pc | i_pop_pc | i_rti | int_ok) begin
        stall_raw  = '1;
        o_stack_en = 1'b1;
        cnt_load   = 1'b1;
        if (i_push_pc)     state_d = ST_CALL;
        else if (i_pop_pc) state_d = ST_RET;
        else if (i_rti)    state_d = ST_RTI;
        else begin
          state_d         = ST_INT;
          o_interrupt_ack = 1'b1;
          flush_v[B_FD]   = 1'b1;
        end
      end else if (i_branch_decision) begin
        flush_v           = '1;
        o_branch_decision = 1'b1;
      end else if (i_load_use) begin
        stall_raw[B_FD] = 1'b1;
        // With a single boundary the bubble would cancel the stall itself.
        if (N_B > 1) flush_v[B_LAST] = 1'b1;
      end
    end else if (!cnt_tc) begin
      stall_raw    = '1;
      o_stack_en   = 1'b1;
      o_stack_beat = count;
      cnt_inc      = 1'b1;
    end else begin
      flush_v           = '1;
      o_branch_decision = 1'b1;
      cnt_clr           = 1'b1;
      state_d           = ST_IDLE;
    end

    flush_v[B_LAST] = flush_v[B_LAST] | i_exm_imm;

    o_flush       = flush_v;
    o_stall       = stall_raw & ~flush_v;
    o_int_blocked = (state_q != ST_IDLE) | i_push_pc | i_pop_pc | i_rti | i_load_use;
    o_state       = state_q;

    if (!i_rst_n) begin
      o_flush           = '0;
      o_stall           = '0;
      o_int_blocked     = 1'b0;
      o_state           = 3'd0;
      o_branch_decision = 1'b0;
      o_stack_en        = 1'b0;
      o_stack_beat      = '0;
      o_interrupt_ack   = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: default configuration plus a
// 5-stage, single-PC-beat instance for the exm_imm boundary case.
module tb_hazard_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default instance: N_B=2, CNT_W=2
  logic a_push, a_pop, a_rti, a_br, a_lu, a_imm, a_irq;
  logic [1:0] a_stall, a_flush, a_beat;
  logic a_bd, a_en, a_ack, a_blk;
  logic [2:0] a_state;

  // Wide instance: N_STAGES=5, PC_BEATS=1, FLAG_BEATS=1 -> N_B=4, CNT_W=2
  logic b_push, b_pop, b_rti, b_br, b_lu, b_imm, b_irq;
  logic [3:0] b_stall, b_flush;
  logic [1:0] b_beat;
  logic b_bd, b_en, b_ack, b_blk;
  logic [2:0] b_state;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_cnt;

  hazard_sequencer dut_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_push_pc(a_push), .i_pop_pc(a_pop), .i_rti(a_rti),
    .i_branch_decision(a_br), .i_load_use(a_lu), .i_exm_imm(a_imm),
    .i_interrupt_req(a_irq),
    .o_stall(a_stall), .o_flush(a_flush), .o_branch_decision(a_bd),
    .o_stack_beat(a_beat), .o_stack_en(a_en), .o_interrupt_ack(a_ack),
    .o_int_blocked(a_blk), .o_state(a_state)
  );

  hazard_sequencer #(.N_STAGES(5), .PC_BEATS(1), .FLAG_BEATS(1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_push_pc(b_push), .i_pop_pc(b_pop), .i_rti(b_rti),
    .i_branch_decision(b_br), .i_load_use(b_lu), .i_exm_imm(b_imm),
    .i_interrupt_req(b_irq),
    .o_stall(b_stall), .o_flush(b_flush), .o_branch_decision(b_bd),
    .o_stack_beat(b_beat), .o_stack_en(b_en), .o_interrupt_ack(b_ack),
    .o_int_blocked(b_blk), .o_state(b_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock, then let new inputs settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    {a_push, a_pop, a_rti, a_br, a_lu, a_imm, a_irq} = '0;
    {b_push, b_pop, b_rti, b_br, b_lu, b_imm, b_irq} = '0;

    // Reset forces outputs low even with triggers present
    a_push = 1'b1; a_irq = 1'b1;
    settle();
    check_eq("rst_stall", a_stall, 2'b00);
    check_eq("rst_flush", a_flush, 2'b00);
    check_eq("rst_en",    a_en, 0);
    check_eq("rst_ack",   a_ack, 0);
    check_eq("rst_blk",   a_blk, 0);
    tick();
    rst_n = 1'b1; a_push = 1'b0; a_irq = 1'b0;
    settle();
    check_eq("rst_state", a_state, 0);
    check_eq("idle_blk",  a_blk, 0);
    $display("test reset done");

    // CALL: 2 beats then release
    a_push = 1'b1;
    settle();
    check_eq("call0_stall", a_stall, 2'b11);
    check_eq("call0_beat",  a_beat, 0);
    check_eq("call0_en",    a_en, 1);
    check_eq("call0_blk",   a_blk, 1);
    tick(); a_push = 1'b0; settle();
    check_eq("call1_state", a_state, 1);
    check_eq("call1_stall", a_stall, 2'b11);
    check_eq("call1_beat",  a_beat, 1);
    tick();
    check_eq("call2_flush", a_flush, 2'b11);
    check_eq("call2_stall", a_stall, 2'b00);
    check_eq("call2_bd",    a_bd, 1);
    check_eq("call2_en",    a_en, 0);
    tick();
    check_eq("call3_state", a_state, 0);
    check_eq("call3_bd",    a_bd, 0);
    $display("test call done");

    // Interrupt entry: 3 beats then release, single ack
    ack_cnt = 0;
    a_irq = 1'b1;
    settle();
    check_eq("int0_ack",   a_ack, 1);
    check_eq("int0_flush", a_flush, 2'b01);
    check_eq("int0_stall", a_stall, 2'b10);
    check_eq("int0_beat",  a_beat, 0);
    if (a_ack) ack_cnt++;
    tick(); a_irq = 1'b0; settle();
    check_eq("int1_state", a_state, 4);
    check_eq("int1_stall", a_stall, 2'b11);
    check_eq("int1_beat",  a_beat, 1);
    if (a_ack) ack_cnt++;
    tick();
    check_eq("int2_beat",  a_beat, 2);
    check_eq("int2_stall", a_stall, 2'b11);
    if (a_ack) ack_cnt++;
    tick();
    check_eq("int3_flush", a_flush, 2'b11);
    check_eq("int3_bd",    a_bd, 1);
    if (a_ack) ack_cnt++;
    check_eq("int_ack_count", ack_cnt, 1);
    tick();
    check_eq("int4_state", a_state, 0);
    $display("test interrupt done");

    // Interrupt raised during RET stays pending until first IDLE cycle
    a_pop = 1'b1;
    settle();
    check_eq("ret0_stall", a_stall, 2'b11);
    tick(); a_pop = 1'b0; a_irq = 1'b1; settle();
    check_eq("ret1_state", a_state, 2);
    check_eq("ret1_ack",   a_ack, 0);
    check_eq("ret1_blk",   a_blk, 1);
    tick();
    check_eq("ret2_bd",    a_bd, 1);
    check_eq("ret2_ack",   a_ack, 0);
    tick();
    check_eq("ret3_state", a_state, 0);
    check_eq("ret3_ack",   a_ack, 1);
    tick(); a_irq = 1'b0;
    tick(); tick(); tick();
    check_eq("ret_int_done", a_state, 0);
    $display("test ret_pending_int done");

    // Branch beats load_use; then load_use alone; interrupt blocked by load_use
    a_br = 1'b1; a_lu = 1'b1;
    settle();
    check_eq("brlu_flush", a_flush, 2'b11);
    check_eq("brlu_stall", a_stall, 2'b00);
    check_eq("brlu_bd",    a_bd, 1);
    a_br = 1'b0; a_irq = 1'b1;
    settle();
    check_eq("lu_stall", a_stall, 2'b01);
    check_eq("lu_flush", a_flush, 2'b10);
    check_eq("lu_bd",    a_bd, 0);
    check_eq("lu_ack",   a_ack, 0);
    check_eq("lu_blk",   a_blk, 1);
    a_lu = 1'b0; a_irq = 1'b0; a_imm = 1'b1;
    settle();
    check_eq("imm_idle_flush", a_flush, 2'b10);
    a_imm = 1'b0;
    tick();
    check_eq("brlu_state", a_state, 0);
    $display("test branch_loaduse done");

    // Reset mid-CALL abandons the sequence
    a_push = 1'b1;
    tick(); a_push = 1'b0; settle();
    check_eq("rcall1_state", a_state, 1);
    rst_n = 1'b0;
    settle();
    check_eq("rcall_rst_stall", a_stall, 2'b00);
    check_eq("rcall_rst_en",    a_en, 0);
    check_eq("rcall_rst_state", a_state, 0);
    tick(); rst_n = 1'b1; settle();
    check_eq("rcall_post_state", a_state, 0);
    check_eq("rcall_post_bd",    a_bd, 0);
    check_eq("rcall_post_flush", a_flush, 2'b00);
    tick();
    check_eq("rcall_post2_bd",   a_bd, 0);
    $display("test reset_mid_call done");

    // Wide instance: exm_imm held through a 1-beat CALL
    b_push = 1'b1; b_imm = 1'b1;
    settle();
    check_eq("b0_flush", b_flush, 4'b1000);
    check_eq("b0_stall", b_stall, 4'b0111);
    check_eq("b0_en",    b_en, 1);
    tick(); b_push = 1'b0; settle();
    check_eq("b1_state", b_state, 1);
    check_eq("b1_flush", b_flush, 4'b1111);
    check_eq("b1_stall", b_stall, 4'b0000);
    check_eq("b1_bd",    b_bd, 1);
    tick();
    check_eq("b2_state", b_state, 0);
    check_eq("b2_flush", b_flush, 4'b1000);
    b_imm = 1'b0; b_lu = 1'b1;
    settle();
    check_eq("b_lu_stall", b_stall, 4'b0001);
    check_eq("b_lu_flush", b_flush, 4'b1000);
    b_lu = 1'b0;
    tick();
    $display("test wide_exm_imm done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
